// File: rtl/nn_pkg.sv
// Shared definitions for the fully-connected layer blocks.
package nn_pkg;

   localparam int unsigned DATA_WIDTH_DEFAULT = 16;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_e;

   // Counter width for n values, never narrower than one bit
   function automatic int unsigned clog2_min1(input int unsigned n);
      int unsigned w;
      w = 32'($clog2(n));
      if (w < 1) w = 1;
      return w;
   endfunction

endpackage

// File: rtl/layer_serializer.sv
// Captures a layer's parallel neuron outputs and replays them as a serial word stream.
module layer_serializer
   import nn_pkg::*;
#(
   parameter int unsigned NN        = 10,
   parameter int unsigned dataWidth = DATA_WIDTH_DEFAULT
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NN-1:0]           i_valid,
   input  logic [NN*dataWidth-1:0] i_data,
   output logic                    o_valid,
   output logic [dataWidth-1:0]    o_data,
   output logic                    o_last,
   output logic                    busy,
   input  logic                    err_clr,
   output logic                    err_overrun,
   output logic                    err_mismatch
);

   localparam int unsigned   CW       = clog2_min1(NN);
   localparam logic [CW-1:0] LAST_IDX = CW'(NN - 1);

   state_e               state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [dataWidth-1:0] buf_q [NN];
   logic [dataWidth-1:0] buf_d [NN];
   logic                 o_valid_q, o_valid_d;
   logic [dataWidth-1:0] o_data_q, o_data_d;
   logic                 o_last_q, o_last_d;
   logic                 err_overrun_q, err_overrun_d;
   logic                 err_mismatch_q, err_mismatch_d;

   logic trig, at_last, load, ovr_ev, mis_ev;

   // Next-state, shadow buffer reload, output preparation and sticky error flags
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      buf_d    = buf_q;

      trig     = i_valid[0];
      mis_ev   = (i_valid != '0) && (i_valid != '1);
      at_last  = (state_q == SEND) && (cnt_q == LAST_IDX);
      load     = trig && ((state_q == IDLE) || at_last);
      ovr_ev   = trig && (state_q == SEND) && !at_last;

      case (state_q)
         IDLE: begin
            if (load) begin
               state_d = SEND;
               cnt_d   = '0;
            end
         end
         SEND: begin
            if (at_last) begin
               cnt_d   = '0;
               state_d = load ? SEND : IDLE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase

      if (load) begin
         for (int unsigned k = 0; k < NN; k++) begin
            buf_d[k] = i_data[k*dataWidth +: dataWidth];
         end
      end

      // Outputs are registered, so they are computed from the upcoming state
      o_valid_d = (state_d == SEND);
      o_data_d  = o_valid_d ? buf_d[cnt_d] : '0;
      o_last_d  = o_valid_d && (cnt_d == LAST_IDX);

      // A new error event wins over a simultaneous clear
      err_overrun_d  = (err_overrun_q && !err_clr) || ovr_ev;
      err_mismatch_d = (err_mismatch_q && !err_clr) || mis_ev;
   end

   // State, counter, buffer and output registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q        <= IDLE;
         cnt_q          <= '0;
         for (int unsigned k = 0; k < NN; k++) begin
            buf_q[k] <= '0;
         end
         o_valid_q      <= 1'b0;
         o_data_q       <= '0;
         o_last_q       <= 1'b0;
         err_overrun_q  <= 1'b0;
         err_mismatch_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         buf_q          <= buf_d;
         o_valid_q      <= o_valid_d;
         o_data_q       <= o_data_d;
         o_last_q       <= o_last_d;
         err_overrun_q  <= err_overrun_d;
         err_mismatch_q <= err_mismatch_d;
      end
   end

   assign o_valid      = o_valid_q;
   assign o_data       = o_data_q;
   assign o_last       = o_last_q;
   assign busy         = (state_q == SEND);
   assign err_overrun  = err_overrun_q;
   assign err_mismatch = err_mismatch_q;

endmodule
